alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Sequencing controller that owns a 4-entry x 4-bit register file and drives the shared 4-bit ALU datapath (ADD/SUB/AND/OR selected by a 2-bit ctrl). It accepts one instruction at a time over a valid/ready handshake, reads its operands, and presents them plus ctrl to the ALU for one cycle. It then captures the ALU result, writes it back, and returns the result to the requester over a second valid/ready handshake.

Parameters:
DATA_W, 4, operand/result width; must match the ALU width.
NREGS, 4, register file depth; register index width is 2.
CNT_W, 8, width of the retired-instruction counter.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
instr_valid  input  1  instruction offered.
instr_ready  output  1  sequencer can accept an instruction.
instr_op  input  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=LDI; 5-7 illegal.
instr_rd  input  2  destination register index.
instr_rs1  input  2  first operand register (ALU A).
instr_rs2  input  2  second operand register (ALU B).
instr_imm  input  DATA_W  immediate for LDI.
alu_a  output  DATA_W  operand A to ALU.
alu_b  output  DATA_W  operand B to ALU.
alu_ctrl  output  2  ALU ctrl/op select.
alu_result  input  DATA_W  combinational ALU result.
res_valid  output  1  result available.
res_ready  input  1  requester takes result.
res_data  output  DATA_W  value written to rd.
res_zero  output  1  res_data == 0.
res_err  output  1  instruction was illegal; no write occurred.
busy  output  1  state != IDLE.
retired_cnt  output  CNT_W  count of completed res handshakes.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, all regs=0, alu_a/alu_b/alu_ctrl=0, res_valid=0, res_data=0, res_zero=0, res_err=0, retired_cnt=0. instr_ready=1 after reset.
- FSM states are IDLE, EXEC, RESP.
- IDLE:
  - instr_ready=1.
  - On instr_valid: latch op/rd/rs1/rs2/imm.
  - For op 0-3, go to EXEC.
  - For LDI, write reg[rd]=imm, set res_data=imm, and go to RESP.
  - For op 5-7, set res_err=1, res_data=0, make no write, and go to RESP.
- EXEC (exactly one cycle):
  - instr_ready=0.
  - alu_a=reg[rs1], alu_b=reg[rs2], alu_ctrl=op[1:0].
  - At the end of the cycle: reg[rd]=alu_result, res_data=alu_result. Go to RESP.
  - Outside EXEC, alu_a/alu_b/alu_ctrl are driven to 0.
- RESP:
  - res_valid=1. res_data, res_zero and res_err are held stable until res_valid&&res_ready.
  - On the handshake: retired_cnt++ (wraps 2^CNT_W-1 -> 0), clear res_err, go to IDLE.
- Latency from accept edge T:
  - ALU ops: EXEC in cycle T+1, res_valid from T+2.
  - LDI/illegal: res_valid from T+1.
  - Minimum issue interval: 3 cycles for ALU ops, 2 for LDI, given res_ready held high.
- No new instruction is accepted while busy. instr_ready is a registered-state decode (IDLE only) and never depends on instr_valid.
- Arithmetic wraps modulo 2^DATA_W, as in the ALU: no carry/borrow is reported.
- Hazards: rd may equal rs1/rs2. Operands are read in EXEC before write-back, so the old value is used.
- res_ready asserted while res_valid=0 has no effect.
- rst_n asserted mid-operation: immediate return to reset values, the in-flight instruction is discarded, no write-back occurs, and retired_cnt is cleared.

Test Plan:
- Reset then LDI r1=9, LDI r2=8, ADD r3=r1+r2 -> res_data=0x1, res_zero=0, reg r3=1, retired_cnt=3. ALU result appears 2 cycles after accept; alu_ctrl=0 in EXEC.
- LDI r0=3, LDI r1=5, SUB r2=r0-r1 -> res_data=0xE. Then AND r3=r2&r1 -> 0x4. Then OR r0=r3|r0 -> 0x7 (r0 was 3). Check alu_a/alu_b/alu_ctrl each EXEC cycle and 0 otherwise.
- Hold res_ready=0 for 5 cycles after res_valid -> res_valid/res_data stable, instr_ready=0, offered instr_valid ignored. Release -> handshake, retired_cnt +1, instr_ready=1 next cycle.
- instr_op=6 -> res_valid after 1 cycle with res_err=1, res_data=0, no register changed. The next instruction completes normally with res_err=0.
- Assert rst_n=0 during EXEC of ADD r3=r1+r2 (r1=9, r2=8) -> outputs and regs return to 0 asynchronously, no res_valid. After release, ADD r3=r1+r2 -> res_data=0, res_zero=1.
- 256 back-to-back LDI with res_ready=1 -> retired_cnt wraps to 0; issue interval is exactly 2 cycles.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Instruction, result and ALU operand bundle between a requester/ALU pair and
// the sequencer.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int IDX_W  = 2
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [IDX_W-1:0]  instr_rd;
    logic [IDX_W-1:0]  instr_rs1;
    logic [IDX_W-1:0]  instr_rs2;
    logic [DATA_W-1:0] instr_imm;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [1:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_result;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_zero;
    logic              res_err;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        output alu_result, res_ready,
        input  instr_ready, alu_a, alu_b, alu_ctrl,
        input  res_valid, res_data, res_zero, res_err
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        input  alu_result, res_ready,
        output instr_ready, alu_a, alu_b, alu_ctrl,
        output res_valid, res_data, res_zero, res_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Single-issue sequencer: owns a small register file, drives the shared ALU for
// one cycle per arithmetic instruction, and returns each result over a handshake.
module alu_op_sequencer #(
    parameter int DATA_W = 4,
    parameter int NREGS  = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_op_sequencer_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] retired_cnt
);
    localparam int IDX_W = $clog2(NREGS);
    localparam logic [2:0] OP_LDI = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [1:0]        ctrl_reg;
    logic [IDX_W-1:0]  rd_reg, rs1_reg, rs2_reg;
    logic [DATA_W-1:0] res_data_reg, res_data_next;
    logic              res_zero_reg, res_zero_next;
    logic              res_err_reg, res_err_next;
    logic [CNT_W-1:0]  retired_cnt_reg, retired_cnt_next;

    logic              latch_en;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        state_next       = state_reg;
        res_data_next    = res_data_reg;
        res_zero_next    = res_zero_reg;
        res_err_next     = res_err_reg;
        retired_cnt_next = retired_cnt_reg;
        latch_en         = 1'b0;
        wr_en            = 1'b0;
        wr_addr          = rd_reg;
        wr_data          = bus.alu_result;

        case (state_reg)
            IDLE: begin
                if (bus.instr_valid) begin
                    latch_en = 1'b1;
                    if (!bus.instr_op[2]) begin
                        state_next = EXEC;
                    end else if (bus.instr_op == OP_LDI) begin
                        // Immediate loads bypass the ALU and retire straight away.
                        wr_en         = 1'b1;
                        wr_addr       = bus.instr_rd;
                        wr_data       = bus.instr_imm;
                        res_data_next = bus.instr_imm;
                        res_zero_next = (bus.instr_imm == '0);
                        res_err_next  = 1'b0;
                        state_next    = RESP;
                    end else begin
                        res_data_next = '0;
                        res_zero_next = 1'b1;
                        res_err_next  = 1'b1;
                        state_next    = RESP;
                    end
                end
            end
            EXEC: begin
                wr_en         = 1'b1;
                res_data_next = bus.alu_result;
                res_zero_next = (bus.alu_result == '0);
                res_err_next  = 1'b0;
                state_next    = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    retired_cnt_next = retired_cnt_reg + CNT_W'(1);
                    res_err_next     = 1'b0;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            res_data_reg    <= '0;
            res_zero_reg    <= 1'b0;
            res_err_reg     <= 1'b0;
            retired_cnt_reg <= '0;
            ctrl_reg        <= '0;
            rd_reg          <= '0;
            rs1_reg         <= '0;
            rs2_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            res_data_reg    <= res_data_next;
            res_zero_reg    <= res_zero_next;
            res_err_reg     <= res_err_next;
            retired_cnt_reg <= retired_cnt_next;
            if (latch_en) begin
                ctrl_reg <= bus.instr_op[1:0];
                rd_reg   <= bus.instr_rd;
                rs1_reg  <= bus.instr_rs1;
                rs2_reg  <= bus.instr_rs2;
            end
        end
    end

    // Register file is fully reset, so it stays in flops rather than block RAM.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_reg[gi] <= '0;
                end else if (wr_en && (wr_addr == IDX_W'(gi))) begin
                    regs_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // Operands are read combinationally in EXEC, before the write-back edge,
    // so rd == rs1/rs2 sees the old value.
    assign bus.alu_a    = (state_reg == EXEC) ? regs_reg[rs1_reg] : '0;
    assign bus.alu_b    = (state_reg == EXEC) ? regs_reg[rs2_reg] : '0;
    assign bus.alu_ctrl = (state_reg == EXEC) ? ctrl_reg : 2'd0;

    assign bus.instr_ready = (state_reg == IDLE);
    assign bus.res_valid   = (state_reg == RESP);
    assign bus.res_data    = res_data_reg;
    assign bus.res_zero    = res_zero_reg;
    assign bus.res_err     = res_err_reg;
    assign busy            = (state_reg != IDLE);
    assign retired_cnt     = retired_cnt_reg;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed vector table, reset and
// wrap sequences, and randomized instructions against a register-file model.
module tb_alu_op_sequencer;
    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [7:0] retired_cnt;

    alu_op_sequencer_if #(.DATA_W(4), .IDX_W(2)) bus ();

    alu_op_sequencer #(.DATA_W(4), .NREGS(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared ALU the sequencer drives.
    always_comb begin
        case (bus.alu_ctrl)
            2'd0:    bus.alu_result = bus.alu_a + bus.alu_b;
            2'd1:    bus.alu_result = bus.alu_a - bus.alu_b;
            2'd2:    bus.alu_result = bus.alu_a & bus.alu_b;
            default: bus.alu_result = bus.alu_a | bus.alu_b;
        endcase
    end

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [3:0] imm;
        int         hold;
        logic [3:0] exp_data;
        logic       exp_err;
    } vec_t;

    int tests_run = 0;
    int tests_failed = 0;
    int mregs [4];
    int mret = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result from the instruction set rules, plain integer arithmetic.
    function automatic int ref_calc(input int op, input int a, input int b, input int imm);
        case (op)
            0:       return (a + b) % 16;
            1:       return (a - b + 16) % 16;
            2:       return a & b;
            3:       return a | b;
            4:       return imm;
            default: return 0;
        endcase
    endfunction

    // Starts and ends on a falling edge with the sequencer idle.
    task automatic run_instr(input string tag, input vec_t v);
        logic [3:0] held;
        check({tag, "_ready_idle"}, 32'(bus.instr_ready), 32'd1);
        check({tag, "_alu_idle"}, {22'd0, bus.alu_ctrl, bus.alu_a, bus.alu_b}, 32'd0);
        bus.instr_valid = 1'b1;
        bus.instr_op    = v.op;
        bus.instr_rd    = v.rd;
        bus.instr_rs1   = v.rs1;
        bus.instr_rs2   = v.rs2;
        bus.instr_imm   = v.imm;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        if (v.op <= 3'd3) begin
            check({tag, "_exec_valid"}, 32'(bus.res_valid), 32'd0);
            check({tag, "_exec_ready"}, 32'(bus.instr_ready), 32'd0);
            check({tag, "_alu_a"}, 32'(bus.alu_a), 32'(mregs[v.rs1]));
            check({tag, "_alu_b"}, 32'(bus.alu_b), 32'(mregs[v.rs2]));
            check({tag, "_alu_ctrl"}, 32'(bus.alu_ctrl), 32'(v.op[1:0]));
            @(negedge clk);
        end
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_res_data"}, 32'(bus.res_data), 32'(v.exp_data));
        check({tag, "_res_zero"}, 32'(bus.res_zero), 32'(v.exp_data == 4'd0));
        check({tag, "_res_err"}, 32'(bus.res_err), 32'(v.exp_err));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_alu_resp"}, {22'd0, bus.alu_ctrl, bus.alu_a, bus.alu_b}, 32'd0);
        held = bus.res_data;
        // While the result is held, offer a competing LDI that must be ignored.
        for (int h = 0; h < v.hold; h++) begin
            bus.instr_valid = 1'b1;
            bus.instr_op    = 3'd4;
            bus.instr_rd    = v.rd;
            bus.instr_imm   = ~v.exp_data;
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.res_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(bus.res_data), 32'(held));
            check({tag, "_hold_ready"}, 32'(bus.instr_ready), 32'd0);
        end
        bus.instr_valid = 1'b0;
        bus.res_ready   = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        mret = (mret + 1) % 256;
        if (v.op <= 3'd4) mregs[v.rd] = int'(v.exp_data);
        check({tag, "_retired"}, 32'(retired_cnt), 32'(mret));
        check({tag, "_ready_after"}, 32'(bus.instr_ready), 32'd1);
        check({tag, "_err_clear"}, 32'(bus.res_err), 32'd0);
        $display("[TB] %s op=%0d rd=%0d rs1=%0d rs2=%0d imm=%0h -> data=%0h err=%0b retired=%0d",
                 tag, v.op, v.rd, v.rs1, v.rs2, v.imm, v.exp_data, v.exp_err, mret);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) mregs[i] = 0;
        mret = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    vec_t tbl [13];
    vec_t v;

    initial begin
        int accepts;
        int last;
        int rop;
        int ra;
        int rb;
        logic [3:0] last_imm;
        logic [1:0] rrd;
        logic [3:0] rimm;

        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_op    = '0;
        bus.instr_rd    = '0;
        bus.instr_rs1   = '0;
        bus.instr_rs2   = '0;
        bus.instr_imm   = '0;
        bus.res_ready   = 1'b0;
        for (int i = 0; i < 4; i++) mregs[i] = 0;

        //          op    rd    rs1   rs2   imm   hold exp   err
        tbl[0]  = '{3'd4, 2'd1, 2'd0, 2'd0, 4'h9, 0, 4'h9, 1'b0};
        tbl[1]  = '{3'd4, 2'd2, 2'd0, 2'd0, 4'h8, 0, 4'h8, 1'b0};
        tbl[2]  = '{3'd0, 2'd3, 2'd1, 2'd2, 4'h0, 0, 4'h1, 1'b0};
        tbl[3]  = '{3'd4, 2'd0, 2'd0, 2'd0, 4'h3, 0, 4'h3, 1'b0};
        tbl[4]  = '{3'd4, 2'd1, 2'd0, 2'd0, 4'h5, 0, 4'h5, 1'b0};
        tbl[5]  = '{3'd1, 2'd2, 2'd0, 2'd1, 4'h0, 0, 4'hE, 1'b0};
        tbl[6]  = '{3'd2, 2'd3, 2'd2, 2'd1, 4'h0, 5, 4'h4, 1'b0};
        tbl[7]  = '{3'd3, 2'd0, 2'd3, 2'd0, 4'h0, 0, 4'h7, 1'b0};
        tbl[8]  = '{3'd6, 2'd1, 2'd0, 2'd0, 4'hA, 1, 4'h0, 1'b1};
        tbl[9]  = '{3'd3, 2'd1, 2'd0, 2'd1, 4'h0, 0, 4'h7, 1'b0};
        tbl[10] = '{3'd4, 2'd2, 2'd0, 2'd0, 4'h0, 0, 4'h0, 1'b0};
        tbl[11] = '{3'd1, 2'd3, 2'd2, 2'd0, 4'h0, 0, 4'h9, 1'b0};
        tbl[12] = '{3'd0, 2'd0, 2'd0, 2'd1, 4'h0, 0, 4'hE, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_res_zero", 32'(bus.res_zero), 32'd0);
        check("rst_res_err", 32'(bus.res_err), 32'd0);
        check("rst_retired", 32'(retired_cnt), 32'd0);
        check("rst_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu", {22'd0, bus.alu_ctrl, bus.alu_a, bus.alu_b}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_instr($sformatf("vec%0d", i), tbl[i]);

        // Reset during EXEC discards the instruction and clears everything.
        run_instr("pre_r1", '{3'd4, 2'd1, 2'd0, 2'd0, 4'h9, 0, 4'h9, 1'b0});
        run_instr("pre_r2", '{3'd4, 2'd2, 2'd0, 2'd0, 4'h8, 0, 4'h8, 1'b0});
        bus.instr_valid = 1'b1;
        bus.instr_op    = 3'd0;
        bus.instr_rd    = 2'd3;
        bus.instr_rs1   = 2'd1;
        bus.instr_rs2   = 2'd2;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check("mid_exec_alu_a", 32'(bus.alu_a), 32'd9);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) mregs[i] = 0;
        mret = 0;
        check("mid_rst_alu", {22'd0, bus.alu_ctrl, bus.alu_a, bus.alu_b}, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_retired", 32'(retired_cnt), 32'd0);
        check("mid_rst_ready", 32'(bus.instr_ready), 32'd1);
        @(negedge clk);
        check("mid_rst_hold_valid", 32'(bus.res_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_instr("post_rst_add", '{3'd0, 2'd3, 2'd1, 2'd2, 4'h0, 0, 4'h0, 1'b0});

        // Randomized instructions against the register-file model.
        for (int n = 0; n < 40; n++) begin
            rop = int'($urandom_range(0, 7));
            v.op  = 3'(rop);
            v.rd  = 2'($urandom_range(0, 3));
            v.rs1 = 2'($urandom_range(0, 3));
            v.rs2 = 2'($urandom_range(0, 3));
            v.imm = 4'($urandom_range(0, 15));
            v.hold = int'($urandom_range(0, 2));
            ra = mregs[v.rs1];
            rb = mregs[v.rs2];
            v.exp_data = 4'(ref_calc(rop, ra, rb, int'(v.imm)));
            v.exp_err  = (rop > 4);
            run_instr($sformatf("rnd%0d", n), v);
        end

        // 256 back-to-back LDIs: counter wraps to zero, issue interval is 2.
        do_reset();
        accepts = 0;
        last = -1;
        last_imm = '0;
        bus.instr_valid = 1'b1;
        bus.instr_op    = 3'd4;
        bus.res_ready   = 1'b1;
        for (int cyc = 0; cyc < 2000 && accepts < 256; cyc++) begin
            if (bus.res_valid) check("wrap_ldi_data", 32'(bus.res_data), 32'(last_imm));
            if (bus.instr_ready) begin
                if (last >= 0) check("wrap_issue_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                accepts++;
                rrd  = 2'($urandom_range(0, 3));
                rimm = 4'($urandom_range(0, 15));
                bus.instr_rd  = rrd;
                bus.instr_imm = rimm;
                mregs[rrd] = int'(rimm);
                last_imm = rimm;
            end
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        check("wrap_accepts", 32'(accepts), 32'd256);
        check("wrap_last_valid", 32'(bus.res_valid), 32'd1);
        check("wrap_last_data", 32'(bus.res_data), 32'(last_imm));
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("wrap_retired", 32'(retired_cnt), 32'd0);
        check("wrap_ready", 32'(bus.instr_ready), 32'd1);
        $display("[TB] wrap: %0d LDIs issued, retired_cnt=%0d", accepts, retired_cnt);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
